fma16_normalize: RTL and testbench
==================================

// Module: fma16_normalize
// PURPOSE
//  Sequential post-add normalizer for the fp16 FMA datapath, sitting between the 34-bit adder and the rounder.
//  Left-shifts the raw magnitude until bit 33 holds the leading one and adjusts the exponent.
//  Emits the truncated fp16 word (sum), the normalized 34-bit magnitude (fullSum) and overFlowFlag.
//  Rounder bit positions on fullSum: lsb=[23], guard=[22], rnd=[21], sticky=|[20:0].
// PARAMETERS
//  EXP_W       7  signed width of in_exp (biased, bias 15, weight of mag bit 33)
//  SHIFT_STEP  4  max left-shift distance per NORM cycle (>=1)
// PORTS
//  clk           in   1      clock, all state on rising edge
//  reset         in   1      synchronous, active-high
//  in_valid      in   1      input operand valid
//  in_ready      out  1      block can accept (high only in IDLE)
//  in_sign       in   1      result sign
//  in_exp        in   EXP_W  signed biased exponent
//  in_mag        in   34     unnormalized magnitude
//  out_valid     out  1      result valid (high only in DONE)
//  out_ready     in   1      downstream (rounder) accepts result
//  sum           out  16     {sign, exp[4:0], fullSum[32:23]}
//  fullSum       out  34     normalized magnitude
//  overFlowFlag  out  1      exponent >= 31 after normalization
//  uf_flag       out  1      result flushed to zero (flush-to-zero build only)
// BEHAVIOUR
//  - One clock (clk); synchronous active-high reset: reset sampled on rising clk edge.
//    Reset -> state IDLE; all outputs 0 except in_ready=1. Reset also applies mid-operation; any in-flight operand is discarded.
//  - FSM states: IDLE, NORM, DENORM, DONE. One operand in flight; no overlap.
//  - IDLE: in_ready=1. in_valid=1 captures sign/exp/mag. Next state:
//    - mag==0 -> DONE; sum={sign,15'b0}, fullSum=0.
//    - exp<=0 -> DENORM.
//    - mag[33]==1 -> DONE.
//    - otherwise -> NORM.
//  - NORM: each cycle the shift distance is:
//    - SHIFT_STEP, if mag[33:34-SHIFT_STEP]==0 and exp-SHIFT_STEP>=1;
//    - else 1.
//    - Shift mag left by that distance (zero fill) and subtract it from exp.
//    - Go to DONE on the same edge when the post-shift mag[33]==1.
//    - exp==1 with mag[33]==0 -> subnormal handling (see CONFIGURATION).
//  - DENORM: each cycle mag>>1, with the shifted-out bit ORed into mag[0] (sticky preserved), and exp+1.
//    Exits when exp==1 -> DONE.
//  - DONE:
//    - out_valid=1; outputs held stable until out_ready=1, then -> IDLE.
//    - Exponent field: exp[4:0] if mag[33]==1, else 5'd0 (subnormal).
//    - exp>=31: overFlowFlag=1, sum={sign,5'h1f,10'h0}; fullSum still carries the normalized mag.
//  - Latency: out_valid rises 1+k cycles after the accept edge, where k = NORM/DENORM cycles.
//  - in_valid while not IDLE is ignored (in_ready=0); upstream holds data.
// CONFIGURATION
//  FMA16_SUBNORM_EN defined:
//    - NORM stops at exp==1 and goes to DONE with exponent field 0.
//    - DENORM is used for exp<=0.
//    - uf_flag tied 0.
//  FMA16_SUBNORM_EN undefined:
//    - Any path that would produce a subnormal (NORM reaching exp==1 with mag[33]==0, or capture with exp<=0) goes directly to DONE.
//    - That result is sum={sign,15'b0}, fullSum=0, uf_flag=1.
//    - The DENORM state is not built.
// TESTING
//  1 in_exp=15, in_mag=34'h2_0000_0000 -> out_valid 1 cycle after accept, sum=16'h3C00, overFlowFlag=0.
//  2 SHIFT_STEP=4, in_exp=18, in_mag=34'h0_4000_0000 -> 3 NORM cycles, out_valid at accept+4, sum=16'h3C00.
//  3 in_exp=31, in_mag=34'h2_0000_0000 -> overFlowFlag=1, sum=16'h7C00; in_sign=1 -> sum=16'hFC00.
//  4 in_exp=0, in_mag=34'h2_0000_0001:
//    - SUBNORM_EN -> sum=16'h0200, fullSum[0]=1.
//    - else -> sum=16'h0000, uf_flag=1.
//  5 out_ready held 0 for 5 cycles in DONE -> sum/fullSum/out_valid stable, in_ready=0; out_ready=1 -> IDLE the next cycle.
//  6 reset pulse during NORM (in_mag=34'h0_0000_0001) -> next cycle IDLE, out_valid=0, in_ready=1, outputs 0.

Source files
------------

// File: rtl/fma16_normalize.sv
// fma16_normalize: sequential post-add normalizer (adder -> rounder) for the fp16 FMA datapath.
// Build option: define FMA16_SUBNORM_EN to keep subnormal results (DENORM path); undefined flushes them to zero.
module fma16_normalize #(
  parameter int EXP_W      = 7,
  parameter int SHIFT_STEP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_sign,
  input  logic signed [EXP_W-1:0] in_exp,
  input  logic [33:0]             in_mag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             sum,
  output logic [33:0]             fullSum,
  output logic                    overFlowFlag,
  output logic                    uf_flag
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_NORM   = 2'd1,
    S_DENORM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
  localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic signed [EXP_W-1:0] EXP_STEP = EXP_W'(SHIFT_STEP);
  localparam logic signed [EXP_W-1:0] EXP_MAX  = EXP_W'(31);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_sign;
  logic                    w_sign_next;
  logic signed [EXP_W-1:0] r_exp;
  logic signed [EXP_W-1:0] w_exp_next;
  logic [33:0]             r_mag;
  logic [33:0]             w_mag_next;
  logic                    r_uf;
  logic                    w_uf_next;

  logic                    w_step_big;
  logic [33:0]             w_norm_mag;
  logic signed [EXP_W-1:0] w_norm_exp;
  logic                    w_ovf;
  logic [4:0]              w_exp_field;

  // A wide step is taken only when it cannot overshoot the leading one or drive exp below 1.
  assign w_step_big = (r_mag[33 -: SHIFT_STEP] == '0) && (r_exp > EXP_STEP);
  assign w_norm_mag = w_step_big ? (r_mag << SHIFT_STEP) : (r_mag << 1);
  assign w_norm_exp = w_step_big ? (r_exp - EXP_STEP) : (r_exp - EXP_ONE);

`ifdef FMA16_SUBNORM_EN
  logic [33:0]             w_denorm_mag;
  logic signed [EXP_W-1:0] w_denorm_exp;

  // Right shift keeps the discarded bit as sticky in bit 0.
  assign w_denorm_mag = {1'b0, r_mag[33:2], r_mag[1] | r_mag[0]};
  assign w_denorm_exp = r_exp + EXP_ONE;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_exp   <= '0;
      r_mag   <= '0;
      r_uf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sign  <= w_sign_next;
      r_exp   <= w_exp_next;
      r_mag   <= w_mag_next;
      r_uf    <= w_uf_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_sign_next  = r_sign;
    w_exp_next   = r_exp;
    w_mag_next   = r_mag;
    w_uf_next    = r_uf;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_next = in_sign;
          w_exp_next  = in_exp;
          w_mag_next  = in_mag;
          w_uf_next   = 1'b0;
          if (in_mag == '0) begin
            w_exp_next   = '0;
            w_state_next = S_DONE;
          end else if (in_exp <= EXP_ZERO) begin
`ifdef FMA16_SUBNORM_EN
            w_state_next = S_DENORM;
`else
            w_exp_next   = '0;
            w_mag_next   = '0;
            w_uf_next    = 1'b1;
            w_state_next = S_DONE;
`endif
          end else if (in_mag[33]) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_NORM;
          end
        end
      end
      S_NORM: begin
        if (r_exp == EXP_ONE) begin
          // Exponent floor reached without a leading one: the result is subnormal.
`ifndef FMA16_SUBNORM_EN
          w_exp_next = '0;
          w_mag_next = '0;
          w_uf_next  = 1'b1;
`endif
          w_state_next = S_DONE;
        end else begin
          w_mag_next = w_norm_mag;
          w_exp_next = w_norm_exp;
          if (w_norm_mag[33]) begin
            w_state_next = S_DONE;
          end
        end
      end
`ifdef FMA16_SUBNORM_EN
      S_DENORM: begin
        w_mag_next = w_denorm_mag;
        w_exp_next = w_denorm_exp;
        if (w_denorm_exp == EXP_ONE) begin
          w_state_next = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    sum          = '0;
    fullSum      = '0;
    overFlowFlag = 1'b0;
    uf_flag      = 1'b0;
    w_ovf        = 1'b0;
    w_exp_field  = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
      end
      S_DONE: begin
        out_valid    = 1'b1;
        fullSum      = r_mag;
        uf_flag      = r_uf;
        w_ovf        = (r_exp >= EXP_MAX);
        overFlowFlag = w_ovf;
        w_exp_field  = r_mag[33] ? r_exp[4:0] : 5'd0;
        sum          = w_ovf ? {r_sign, 5'h1f, 10'h000} : {r_sign, w_exp_field, r_mag[32:23]};
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_fma16_normalize.sv
// Scoreboard bench for fma16_normalize: expectations queued at accept, compared when the result appears.
module tb_fma16_normalize;

  localparam int STEP = 4;

  typedef struct {
    logic [15:0] sum;
    logic [33:0] full;
    logic        ovf;
    logic        uf;
    int          lat;
    int          acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic signed [6:0] in_exp;
  logic [33:0]       in_mag;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       sum;
  logic [33:0]       fullSum;
  logic              overFlowFlag;
  logic              uf_flag;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errs = 0;
  bit   seen = 1'b0;

  fma16_normalize #(.EXP_W(7), .SHIFT_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mag(in_mag),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .fullSum(fullSum),
    .overFlowFlag(overFlowFlag), .uf_flag(uf_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errs++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // Reference: normalize via leading-one position, count cycles under the step policy.
  function automatic exp_t model(input logic s, input int e, input logic [33:0] m);
    exp_t r;
    int p, l, ee, rem, k, n;
    logic st;
    logic [33:0] f;
    r.sum = '0; r.full = '0; r.ovf = 1'b0; r.uf = 1'b0; r.acc = 0;
    k = 0;
    if (m == '0) begin
      r.sum = {s, 15'b0};
    end else if (e <= 0) begin
`ifdef FMA16_SUBNORM_EN
      n = 1 - e;
      st = 1'b0;
      for (int i = 0; i < 34; i++) if (i < n && m[i]) st = 1'b1;
      f = m >> n;
      f[0] = f[0] | st;
      r.full = f;
      r.sum = {s, 5'b0, f[32:23]};
      k = n;
`else
      r.sum = {s, 15'b0};
      r.uf = 1'b1;
`endif
    end else begin
      p = 0;
      for (int i = 0; i < 34; i++) if (m[i]) p = i;
      l = 33 - p;
      ee = e;
      rem = l;
      while ((e - l >= 1) ? (rem > 0) : (ee > 1)) begin
        if (rem >= STEP && ee - STEP >= 1) begin
          rem -= STEP; ee -= STEP;
        end else begin
          rem -= 1; ee -= 1;
        end
        k++;
      end
      if (e - l >= 1) begin
        f = m << l;
        r.full = f;
        r.ovf = (ee >= 31);
        r.sum = r.ovf ? {s, 5'h1f, 10'h000} : {s, 5'(ee), f[32:23]};
      end else begin
        k++;
        f = m << (e - 1);
`ifdef FMA16_SUBNORM_EN
        r.full = f;
        r.sum = {s, 5'b0, f[32:23]};
`else
        r.sum = {s, 15'b0};
        r.uf = 1'b1;
`endif
      end
    end
    r.lat = 1 + k;
    return r;
  endfunction

  task automatic send(input logic s, input int e, input logic [33:0] m, input bit push);
    int g;
    exp_t x;
    g = 0;
    while (!in_ready && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) begin
      check("in_ready_timeout", 64'(in_ready), 64'(1));
      return;
    end
    in_valid = 1'b1;
    in_sign = s;
    in_exp = 7'(e);
    in_mag = m;
    @(posedge clk);
    x = model(s, e, m);
    x.acc = cyc;
    if (push) sb.push_back(x);
    #1;
    in_valid = 1'b0;
    $display("sent sign=%0d exp=%0d mag=%09h exp_sum=%04h lat=%0d", s, e, m, x.sum, x.lat);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 3000) begin
      @(posedge clk);
      g++;
    end
    #1;
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  // Output monitor: compare on first appearance, retire on handshake.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_out_valid", 64'(out_valid), 64'(0));
        end else begin
          cur = sb[0];
          if (!seen) begin
            seen = 1'b1;
            check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
            check("sum", 64'(sum), 64'(cur.sum));
            check("fullSum", 64'(fullSum), 64'(cur.full));
            check("overFlowFlag", 64'(overFlowFlag), 64'(cur.ovf));
            check("uf_flag", 64'(uf_flag), 64'(cur.uf));
            $display("result sum=%04h fullSum=%09h ovf=%0d uf=%0d", sum, fullSum, overFlowFlag, uf_flag);
          end
          if (out_ready) begin
            cur = sb.pop_front();
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t hold;
    int g;
    int e;
    int p;
    logic [33:0] m;
    reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum", 64'(sum), 64'(0));
    check("rst_fullSum", 64'(fullSum), 64'(0));
    check("rst_ovf", 64'(overFlowFlag), 64'(0));
    check("rst_uf", 64'(uf_flag), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;

    send(1'b0, 15, 34'h2_0000_0000, 1'b1);
    send(1'b0, 18, 34'h0_4000_0000, 1'b1);
    send(1'b0, 31, 34'h2_0000_0000, 1'b1);
    send(1'b1, 31, 34'h2_0000_0000, 1'b1);
    send(1'b0, 0, 34'h2_0000_0001, 1'b1);
    send(1'b0, 1, 34'h0_8000_0000, 1'b1);
    send(1'b0, 5, 34'h0_0000_0001, 1'b1);
    send(1'b1, -3, 34'h3_0000_0007, 1'b1);
    send(1'b1, 20, 34'h0_0000_0000, 1'b1);
    send(1'b0, 63, 34'h0_0000_0001, 1'b1);
    send(1'b0, 40, 34'h0_0100_0000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      e = int'($urandom_range(0, 65)) - 20;
      p = int'($urandom_range(0, 33));
      m = 34'({$urandom, $urandom});
      m = m >> (33 - p);
      m[p] = 1'b1;
      if ($urandom_range(0, 15) == 0) m = '0;
      send(1'($urandom_range(0, 1)), e, m, 1'b1);
    end
    drain();

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    hold = model(1'b1, 20, 34'h1_0000_0000);
    send(1'b1, 20, 34'h1_0000_0000, 1'b1);
    g = 0;
    while (!out_valid && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("hold_out_valid_seen", 64'(out_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_in_ready", 64'(in_ready), 64'(0));
      check("hold_sum", 64'(sum), 64'(hold.sum));
      check("hold_fullSum", 64'(fullSum), 64'(hold.full));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready", 64'(in_ready), 64'(1));
    check("release_out_valid", 64'(out_valid), 64'(0));
    drain();

    // Reset in the middle of a long NORM sequence discards the operand.
    send(1'b0, 40, 34'h0_0000_0001, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_in_ready", 64'(in_ready), 64'(1));
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_sum", 64'(sum), 64'(0));
    check("midrst_fullSum", 64'(fullSum), 64'(0));
    check("midrst_ovf", 64'(overFlowFlag), 64'(0));
    send(1'b0, 15, 34'h2_0000_0000, 1'b1);
    send(1'b0, 2, 34'h0_0000_0100, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
